// File: rtl/aiv_capture_packer.sv
// aiv_capture_packer: packs synchronised RGB pixels into SRAM words, queues
// each {addr, data} pair in a small FIFO and offers the head to the SRAM
// arbiter over a wr_req/wr_ack handshake. Drops on a full FIFO are reported
// per field through a sticky flag and a saturating counter.
module aiv_capture_packer #(
  parameter int unsigned BITS_PER_CHANNEL = 1,
  parameter int unsigned WORD_WIDTH       = 16,
  parameter int unsigned ADDR_WIDTH       = 18,
  parameter int unsigned LINE_STRIDE      = 128,
  parameter int unsigned INTERLACED       = 1,
  parameter int unsigned FIFO_DEPTH       = 8
) (
  input  logic                          sysClk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          field_odd,
  input  logic                          pixel_valid,
  input  logic [3*BITS_PER_CHANNEL-1:0] pixel_in,
  output logic                          wr_req,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [WORD_WIDTH-1:0]         wr_data,
  input  logic                          wr_ack,
  output logic                          overflow,
  output logic [7:0]                    words_dropped
);

  localparam int unsigned PIX_W     = 3 * BITS_PER_CHANNEL;
  localparam int unsigned PPW       = WORD_WIDTH / PIX_W;
  localparam int unsigned IDX_W     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENTRY_W   = ADDR_WIDTH + WORD_WIDTH;
  localparam int unsigned LINE_STEP = LINE_STRIDE * ((INTERLACED != 0) ? 2 : 1);
  localparam int unsigned ODD_BASE  = (INTERLACED != 0) ? LINE_STRIDE : 0;

  // capture / packing state
  logic                  pv_q;
  logic                  first_line_q, first_line_d;
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [IDX_W-1:0]      pix_idx_q, pix_idx_d;
  logic [WORD_WIDTH-1:0] pack_q, pack_d;

  // FIFO state; head_q mirrors the entry at the read pointer
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [ENTRY_W-1:0]    head_q, head_d;

  // drop reporting
  logic                  overflow_q, overflow_d;
  logic [7:0]            dropped_q, dropped_d;

  logic                  rise_c, fall_c;
  logic                  push_c, pop_c, full_c, accept_c, drop_c;
  logic [ENTRY_W-1:0]    push_entry_c;
  logic [WORD_WIDTH-1:0] word_cur_c;

  // line/field tracking and pixel packing; produces at most one push per cycle
  always_comb begin
    first_line_d = first_line_q;
    line_base_d  = line_base_q;
    word_idx_d   = word_idx_q;
    pix_idx_d    = pix_idx_q;
    pack_d       = pack_q;
    push_c       = 1'b0;
    push_entry_c = '0;
    word_cur_c   = '0;
    rise_c       = pixel_valid & ~pv_q;
    fall_c       = ~pixel_valid & pv_q;

    if (frame_start) begin
      // new field: a pending partial word (or a coincident flush) is discarded
      line_base_d  = (field_odd && (INTERLACED != 0)) ? ADDR_WIDTH'(ODD_BASE) : '0;
      word_idx_d   = '0;
      pix_idx_d    = '0;
      pack_d       = '0;
      first_line_d = ~pixel_valid;
    end else if (rise_c) begin
      if (!first_line_q) begin
        line_base_d = line_base_q + ADDR_WIDTH'(LINE_STEP);
      end
      first_line_d = 1'b0;
      word_idx_d   = '0;
      pix_idx_d    = '0;
      pack_d       = '0;
    end else if (fall_c && (pix_idx_q != '0)) begin
      // line-end flush of a partial word; empty slots are already zero
      push_c       = 1'b1;
      push_entry_c = {ADDR_WIDTH'(line_base_q + word_idx_q), pack_q};
      word_idx_d   = word_idx_q + ADDR_WIDTH'(1);
      pix_idx_d    = '0;
      pack_d       = '0;
    end

    if (pixel_valid) begin
      word_cur_c = pack_d;
      for (int unsigned k = 0; k < PPW; k++) begin
        if (pix_idx_d == IDX_W'(k)) begin
          word_cur_c[k*PIX_W +: PIX_W] = pixel_in;
        end
      end
      if (pix_idx_d == IDX_W'(PPW - 1)) begin
        push_c       = 1'b1;
        push_entry_c = {ADDR_WIDTH'(line_base_d + word_idx_d), word_cur_c};
        word_idx_d   = word_idx_d + ADDR_WIDTH'(1);
        pix_idx_d    = '0;
        pack_d       = '0;
      end else begin
        pix_idx_d = pix_idx_d + IDX_W'(1);
        pack_d    = word_cur_c;
      end
    end
  end

  // FIFO next state: push+pop together always succeeds, even when full
  always_comb begin
    mem_d    = mem_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    pop_c    = req_q & wr_ack;
    full_c   = (cnt_q == CNT_W'(FIFO_DEPTH));
    accept_c = push_c & (~full_c | pop_c);
    drop_c   = push_c & full_c & ~pop_c;

    if (accept_c) begin
      mem_d[wr_q] = push_entry_c;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({accept_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    req_d  = (cnt_d != '0);
    head_d = mem_d[rd_d];
  end

  // per-field drop reporting; frame_start clears before a same-cycle drop counts
  always_comb begin
    overflow_d = frame_start ? 1'b0 : overflow_q;
    dropped_d  = frame_start ? 8'd0 : dropped_q;
    if (drop_c) begin
      overflow_d = 1'b1;
      if (dropped_d != 8'hFF) begin
        dropped_d = dropped_d + 8'd1;
      end
    end
  end

  // state registers
  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      pv_q         <= 1'b0;
      first_line_q <= 1'b1;
      line_base_q  <= '0;
      word_idx_q   <= '0;
      pix_idx_q    <= '0;
      pack_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q         <= '0;
      wr_q         <= '0;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
      dropped_q    <= 8'd0;
    end else begin
      pv_q         <= pixel_valid;
      first_line_q <= first_line_d;
      line_base_q  <= line_base_d;
      word_idx_q   <= word_idx_d;
      pix_idx_q    <= pix_idx_d;
      pack_q       <= pack_d;
      mem_q        <= mem_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  assign wr_req        = req_q;
  assign wr_addr       = head_q[ENTRY_W-1 -: ADDR_WIDTH];
  assign wr_data       = head_q[WORD_WIDTH-1:0];
  assign overflow      = overflow_q;
  assign words_dropped = dropped_q;

endmodule

// File: doc/aiv_capture_packer.md
Name: aiv_capture_packer

Overview:
- Parametrised successor to the AIV capture front-end.
- Sits between the active-frame tracker and the SRAM arbiter.
- Takes synchronised RGB pixels of configurable depth and packs several pixels into each SRAM word.
- Queues each word with its computed address in a small FIFO and issues it to the arbiter through a req/ack handshake.
- Provides interlaced (field-to-odd/even-line) addressing, partial-word flush at line end, and sticky overflow reporting, none of which the RGB111-only path has.

Parameters:
- BITS_PER_CHANNEL, 1, bits per R/G/B channel; PIX_W = 3*BITS_PER_CHANNEL.
- WORD_WIDTH, 16, SRAM data word width; PPW = floor(WORD_WIDTH/PIX_W), must be ≥1.
- ADDR_WIDTH, 18, SRAM word address width.
- LINE_STRIDE, 128, word-address distance between consecutive frame lines.
- INTERLACED, 1, 1 = field lines interleave into frame (odd field on odd frame lines); 0 = progressive.
- FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2).

Ports:
- sysClk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse marking the start of a field.
- field_odd  in  1  field parity; sampled on frame_start.
- pixel_valid  in  1  display enable; high for active pixels.
- pixel_in  in  PIX_W  pixel as {R,G,B}; each channel is BITS_PER_CHANNEL wide, MSB first.
- wr_req  out  1  FIFO head valid.
- wr_addr  out  ADDR_WIDTH  head word address.
- wr_data  out  WORD_WIDTH  head packed word.
- wr_ack  in  1  arbiter accepted the head; pops it this cycle.
- overflow  out  1  sticky; at least one word dropped this field.
- words_dropped  out  8  saturating count of words dropped this field.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; wr_req=0, wr_addr=0, wr_data=0.
  - overflow=0, words_dropped=0.
  - Pack register, pixel index, word index and line base all cleared.
- Packing:
  - Pixel k of a word (k=0..PPW-1) occupies bits [k*PIX_W +: PIX_W]. The first pixel goes in the LSBs.
  - Unused upper bits (WORD_WIDTH − PPW*PIX_W) are always 0.
  - A word completes on the cycle its PPW-th pixel is sampled.
- Line-end flush:
  - On a falling edge of pixel_valid with a non-zero pixel index, the partial word is pushed, zero-padded in the missing slots.
  - With a zero pixel index, nothing is pushed.
- Addressing:
  - Word address = line_base + word_index, modulo 2^ADDR_WIDTH. word_index resets to 0 on each rising edge of pixel_valid.
  - On frame_start: line_base = (INTERLACED && field_odd) ? LINE_STRIDE : 0; the pack register and pixel index are discarded.
  - On each rising edge of pixel_valid other than the first in a field, line_base += LINE_STRIDE*(INTERLACED?2:1), wrapping modulo 2^ADDR_WIDTH.
- Simultaneous events:
  - frame_start in the same cycle as pixel_valid: frame_start is applied first, and the pixel becomes pixel 0 of the new field's first line.
  - frame_start in the same cycle as a line-end flush: the flush is discarded.
- FIFO:
  - Each entry is {addr, data}. wr_req = !empty. wr_addr/wr_data show the head registered, with no combinational path from pixel_in.
  - Latency: a word completing at cycle N into an empty FIFO gives wr_req=1 with that word at cycle N+1.
  - wr_ack while wr_req=0 is ignored.
  - Push and pop in the same cycle: both happen and occupancy is unchanged. This applies when full too, so a push into a full FIFO with wr_ack=1 is accepted.
  - Push when full and wr_ack=0: the word is dropped, overflow is set, and words_dropped increments, saturating at 255.
- frame_start:
  - Clears overflow and words_dropped.
  - Does not flush the FIFO; words already queued still drain in order.
- Reset mid-operation: queued words are lost and no partial word is emitted.

Test Plan:
- BPC=1, WORD=16 (PPW=5), frame_start with field_odd=0, then 5 pixels 1,2,3,4,5 with wr_ack=1 → one write: addr 0x00000, data 0x58D1, wr_req high one cycle after the 5th pixel.
- 7 pixels of value 7, then pixel_valid falls → writes (0x00000, 0x7FFF) then (0x00001, 0x003F).
- INTERLACED=1, LINE_STRIDE=64, frame_start with field_odd=1, two lines of 5 pixels → first-word addresses 64 then 192. The same stimulus with INTERLACED=0 and field_odd=0 → 0 then 64.
- FIFO_DEPTH=4, wr_ack=0, 30 pixels → wr_req=1, 4 entries held, overflow=1, words_dropped=2. Then release wr_ack → exactly 4 writes to addr 0..3 in order. The next frame_start clears overflow.
- BPC=2, WORD=16 (PPW=2, bit 12..15 zero), pixels 0x3F, 0x15 → data 0x057F.
- Assert reset while the FIFO holds 3 words and a partial word is pending → wr_req=0 within the same cycle. After release, the next field's first word goes to addr 0, with no stale data.
